// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: pixel clock-enable divider,
// horizontal/vertical counters and registered, mutually aligned sync/position outputs.
module vga_timing_gen #(
    parameter int clkdiv      = 4,
    parameter int hvisible    = 640,
    parameter int hfrontporch = 16,
    parameter int hsyncwidth  = 96,
    parameter int hbackporch  = 48,
    parameter int vvisible    = 480,
    parameter int vfrontporch = 10,
    parameter int vsyncwidth  = 2,
    parameter int vbackporch  = 33,
    parameter bit hsync_pol   = 1'b0,
    parameter bit vsync_pol   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pix_ce,
    output logic        hsync,
    output logic        vsync,
    output logic        vid_ena,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        new_line,
    output logic        new_frame
);

    localparam int HTOTAL = hvisible + hfrontporch + hsyncwidth + hbackporch;
    localparam int VTOTAL = vvisible + vfrontporch + vsyncwidth + vbackporch;

    localparam logic [10:0] H_LAST   = 11'(HTOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(hvisible);
    localparam logic [10:0] HS_BEGIN = 11'(hvisible + hfrontporch);
    localparam logic [10:0] HS_END   = 11'(hvisible + hfrontporch + hsyncwidth);
    localparam logic [10:0] V_LAST   = 11'(VTOTAL - 1);
    localparam logic [10:0] V_VIS    = 11'(vvisible);
    localparam logic [10:0] VS_BEGIN = 11'(vvisible + vfrontporch);
    localparam logic [10:0] VS_END   = 11'(vvisible + vfrontporch + vsyncwidth);
    localparam logic [3:0]  DIV_LAST = 4'(clkdiv - 1);

    logic [3:0]  div_q, div_d;
    logic        tick;
    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_d, vsync_d, vid_ena_d;
    logic        line_start, frame_start;

    logic        pix_ce_q, hsync_q, vsync_q, vid_ena_q;
    logic        new_line_q, new_frame_q;
    logic [10:0] xpos_q, ypos_q;

    // Every output is computed from the post-advance counters so that the
    // registered values line up with the pix_ce pulse issued on the same edge.
    always_comb begin
        tick     = (div_q == DIV_LAST);
        div_d    = tick ? 4'd0 : div_q + 4'd1;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (tick) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 11'd0;
                vcount_d = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end
        vid_ena_d   = (hcount_d < H_VIS) && (vcount_d < V_VIS);
        hsync_d     = (hcount_d >= HS_BEGIN && hcount_d < HS_END) ? hsync_pol : ~hsync_pol;
        vsync_d     = (vcount_d >= VS_BEGIN && vcount_d < VS_END) ? vsync_pol : ~vsync_pol;
        line_start  = tick && (hcount_d == 11'd0);
        frame_start = line_start && (vcount_d == 11'd0);
    end

    // Counters reset to the last position so the first advance lands on (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= 4'd0;
            hcount_q    <= H_LAST;
            vcount_q    <= V_LAST;
            pix_ce_q    <= 1'b0;
            vid_ena_q   <= 1'b0;
            new_line_q  <= 1'b0;
            new_frame_q <= 1'b0;
            hsync_q     <= ~hsync_pol;
            vsync_q     <= ~vsync_pol;
            xpos_q      <= 11'd0;
            ypos_q      <= 11'd0;
        end else begin
            div_q       <= div_d;
            pix_ce_q    <= tick;
            new_line_q  <= line_start;
            new_frame_q <= frame_start;
            if (tick) begin
                hcount_q  <= hcount_d;
                vcount_q  <= vcount_d;
                xpos_q    <= hcount_d;
                ypos_q    <= vcount_d;
                vid_ena_q <= vid_ena_d;
                hsync_q   <= hsync_d;
                vsync_q   <= vsync_d;
            end
        end
    end

    assign pix_ce    = pix_ce_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign vid_ena   = vid_ena_q;
    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign new_line  = new_line_q;
    assign new_frame = new_frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Checks three timing configurations against an arithmetic raster model indexed by
// the number of clocks since reset was released.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic pce_a, hs_a, vs_a, ve_a, nl_a, nf_a;
    logic pce_b, hs_b, vs_b, ve_b, nl_b, nf_b;
    logic pce_c, hs_c, vs_c, ve_c, nl_c, nf_c;
    logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;

    int t_a = 0, t_b = 0, t_c = 0;
    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic        pix_ce;
        logic        hsync;
        logic        vsync;
        logic        vid_ena;
        logic        new_line;
        logic        new_frame;
        logic [10:0] xpos;
        logic [10:0] ypos;
    } out_t;

    // A: default 640x480, B: tiny clkdiv=1 raster, C: small clkdiv=3 raster.
    vga_timing_gen dut_a (
        .clk(clk), .reset(rst_a), .pix_ce(pce_a), .hsync(hs_a), .vsync(vs_a),
        .vid_ena(ve_a), .xpos(x_a), .ypos(y_a), .new_line(nl_a), .new_frame(nf_a)
    );

    vga_timing_gen #(
        .clkdiv(1), .hvisible(4), .hfrontporch(2), .hsyncwidth(2), .hbackporch(2),
        .vvisible(3), .vfrontporch(1), .vsyncwidth(1), .vbackporch(1),
        .hsync_pol(1'b1), .vsync_pol(1'b0)
    ) dut_b (
        .clk(clk), .reset(rst_b), .pix_ce(pce_b), .hsync(hs_b), .vsync(vs_b),
        .vid_ena(ve_b), .xpos(x_b), .ypos(y_b), .new_line(nl_b), .new_frame(nf_b)
    );

    vga_timing_gen #(
        .clkdiv(3), .hvisible(12), .hfrontporch(2), .hsyncwidth(3), .hbackporch(3),
        .vvisible(5), .vfrontporch(1), .vsyncwidth(2), .vbackporch(2),
        .hsync_pol(1'b0), .vsync_pol(1'b1)
    ) dut_c (
        .clk(clk), .reset(rst_c), .pix_ce(pce_c), .hsync(hs_c), .vsync(vs_c),
        .vid_ena(ve_c), .xpos(x_c), .ypos(y_c), .new_line(nl_c), .new_frame(nf_c)
    );

    always @(posedge clk) t_a <= rst_a ? 0 : t_a + 1;
    always @(posedge clk) t_b <= rst_b ? 0 : t_b + 1;
    always @(posedge clk) t_c <= rst_c ? 0 : t_c + 1;

    // Raster position is the count of completed pixel periods, folded by the frame size.
    function automatic out_t model(input int cfg, input int t);
        int cd, hv, hf, hw, hb, vv, vf, vw, vb, ht, vt, n, p, x, y;
        bit hp, vp;
        out_t r;
        case (cfg)
            0: begin cd = 4; hv = 640; hf = 16; hw = 96; hb = 48;
                     vv = 480; vf = 10; vw = 2; vb = 33; hp = 0; vp = 0; end
            1: begin cd = 1; hv = 4; hf = 2; hw = 2; hb = 2;
                     vv = 3; vf = 1; vw = 1; vb = 1; hp = 1; vp = 0; end
            default: begin cd = 3; hv = 12; hf = 2; hw = 3; hb = 3;
                     vv = 5; vf = 1; vw = 2; vb = 2; hp = 0; vp = 1; end
        endcase
        ht = hv + hf + hw + hb;
        vt = vv + vf + vw + vb;
        r = '0;
        r.hsync = ~hp;
        r.vsync = ~vp;
        if (t >= cd) begin
            n = t / cd;
            p = (n - 1) % (ht * vt);
            x = p % ht;
            y = p / ht;
            r.pix_ce    = (t % cd == 0);
            r.xpos      = 11'(x);
            r.ypos      = 11'(y);
            r.vid_ena   = (x < hv) && (y < vv);
            r.hsync     = (x >= hv + hf && x < hv + hf + hw) ? hp : ~hp;
            r.vsync     = (y >= vv + vf && y < vv + vf + vw) ? vp : ~vp;
            r.new_line  = r.pix_ce && (x == 0);
            r.new_frame = r.pix_ce && (p == 0);
        end
        return r;
    endfunction

    task automatic test_reset();
        out_t act;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (3) @(negedge clk);
        act = {pce_a, hs_a, vs_a, ve_a, nl_a, nf_a, x_a, y_a};
        checks++;
        if (act !== out_t'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0}))
            $display("FAIL reset_a actual=%h required=%h", act, out_t'({6'b011000, 22'd0}));
        else passed++;
        act = {pce_b, hs_b, vs_b, ve_b, nl_b, nf_b, x_b, y_b};
        checks++;
        if (act !== out_t'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0}))
            $display("FAIL reset_b actual=%h required=%h", act, out_t'({6'b001000, 22'd0}));
        else passed++;
        act = {pce_c, hs_c, vs_c, ve_c, nl_c, nf_c, x_c, y_c};
        checks++;
        if (act !== out_t'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0}))
            $display("FAIL reset_c actual=%h required=%h", act, out_t'({6'b010000, 22'd0}));
        else passed++;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        $display("[tb] reset held 3 clks and released on all instances");
    endtask

    task automatic test_default_lines();
        out_t act, exp;
        int first_nf = -1, last_pce = -1, bad_pce = 0, nl0 = -1, nl1 = -1;
        int hs_low = 0, hs_min = 2047, hs_max = -1, ve_hi = 0, ve_max = -1;
        for (int i = 0; i < 6500; i++) begin
            @(negedge clk);
            act = {pce_a, hs_a, vs_a, ve_a, nl_a, nf_a, x_a, y_a};
            exp = model(0, t_a);
            checks++;
            if (act !== exp) $display("FAIL default_cycle t=%0d actual=%h required=%h", t_a, act, exp);
            else passed++;
            if (nf_a === 1'b1 && first_nf < 0) first_nf = t_a;
            if (pce_a === 1'b1) begin
                if (last_pce >= 0 && t_a - last_pce != 4) bad_pce++;
                last_pce = t_a;
            end
            if (nl_a === 1'b1) begin
                if (nl0 < 0) nl0 = t_a; else if (nl1 < 0) nl1 = t_a;
            end
            if (t_a >= 4 && y_a == 11'd0 && nl1 < 0) begin
                if (hs_a === 1'b0) begin
                    hs_low++;
                    if (int'(x_a) < hs_min) hs_min = int'(x_a);
                    if (int'(x_a) > hs_max) hs_max = int'(x_a);
                end
                if (ve_a === 1'b1) begin
                    ve_hi++;
                    if (int'(x_a) > ve_max) ve_max = int'(x_a);
                end
            end
        end
        checks++;
        if (first_nf != 4) $display("FAIL first_new_frame actual=%0d required=4", first_nf);
        else passed++;
        checks++;
        if (bad_pce != 0 || last_pce < 0) $display("FAIL pix_ce_period bad_intervals=%0d required=0", bad_pce);
        else passed++;
        checks++;
        if (nl1 - nl0 != 3200 || nl0 < 0) $display("FAIL new_line_period actual=%0d required=3200", nl1 - nl0);
        else passed++;
        checks++;
        if (hs_low != 384 || hs_min != 656 || hs_max != 751)
            $display("FAIL line0_hsync clks=%0d x=%0d..%0d required 384 clks x=656..751", hs_low, hs_min, hs_max);
        else passed++;
        checks++;
        if (ve_hi != 2560 || ve_max != 639)
            $display("FAIL line0_vid_ena clks=%0d maxx=%0d required 2560 clks maxx=639", ve_hi, ve_max);
        else passed++;
        $display("[tb] default config: first two lines compared");
    endtask

    task automatic test_small_frame();
        out_t act, exp;
        int pce_low = 0, hs_bad = 0, hs_seen = 0, last_nf = -1, nf_bad = 0, nf_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            act = {pce_b, hs_b, vs_b, ve_b, nl_b, nf_b, x_b, y_b};
            exp = model(1, t_b);
            checks++;
            if (act !== exp) $display("FAIL small_cycle t=%0d actual=%h required=%h", t_b, act, exp);
            else passed++;
            if (pce_b !== 1'b1) pce_low++;
            if (hs_b === 1'b1) begin
                if (x_b != 11'd6 && x_b != 11'd7) hs_bad++;
                else hs_seen++;
            end
            if (nf_b === 1'b1) begin
                if (last_nf >= 0 && t_b - last_nf != 60) nf_bad++;
                last_nf = t_b;
                nf_cnt++;
            end
        end
        checks++;
        if (pce_low != 0) $display("FAIL small_pix_ce_const low_clks=%0d required=0", pce_low);
        else passed++;
        checks++;
        if (hs_bad != 0 || hs_seen == 0) $display("FAIL small_hsync outside=%0d inside=%0d required outside=0", hs_bad, hs_seen);
        else passed++;
        checks++;
        if (nf_bad != 0 || nf_cnt < 3) $display("FAIL small_frame_period bad=%0d frames=%0d required period 60", nf_bad, nf_cnt);
        else passed++;
        $display("[tb] clkdiv=1 config: 200 clks compared");
    endtask

    task automatic test_scaled_frame();
        out_t act, exp;
        int last_nf = -1, nf_bad = 0, vs_bad = 0, vs_seen = 0, ve_bad = 0, y_bad = 0, y_max = 0, vs_edge_bad = 0;
        logic prev_vs = 1'bx;
        logic [10:0] prev_y = 11'd0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            act = {pce_c, hs_c, vs_c, ve_c, nl_c, nf_c, x_c, y_c};
            exp = model(2, t_c);
            checks++;
            if (act !== exp) $display("FAIL scaled_cycle t=%0d actual=%h required=%h", t_c, act, exp);
            else passed++;
            if (nf_c === 1'b1) begin
                if (last_nf >= 0 && t_c - last_nf != 600) nf_bad++;
                last_nf = t_c;
            end
            if (vs_c === 1'b1) begin
                if (y_c != 11'd6 && y_c != 11'd7) vs_bad++; else vs_seen++;
            end
            if (prev_vs !== 1'bx && vs_c !== prev_vs && x_c != 11'd0) vs_edge_bad++;
            if (ve_c === 1'b1 && y_c >= 11'd5) ve_bad++;
            if (y_c != prev_y && y_c != prev_y + 11'd1 && !(prev_y == 11'd9 && y_c == 11'd0)) y_bad++;
            if (int'(y_c) > y_max) y_max = int'(y_c);
            prev_vs = vs_c;
            prev_y = y_c;
        end
        checks++;
        if (nf_bad != 0 || last_nf < 0) $display("FAIL scaled_frame_period bad=%0d required period 600", nf_bad);
        else passed++;
        checks++;
        if (vs_bad != 0 || vs_seen == 0 || vs_edge_bad != 0)
            $display("FAIL scaled_vsync outside=%0d inside=%0d offedge=%0d required outside=0 offedge=0", vs_bad, vs_seen, vs_edge_bad);
        else passed++;
        checks++;
        if (ve_bad != 0 || y_bad != 0 || y_max != 9)
            $display("FAIL scaled_ypos ve_blank=%0d seq_bad=%0d ymax=%0d required 0/0/9", ve_bad, y_bad, y_max);
        else passed++;
        $display("[tb] clkdiv=3 config: 1500 clks compared");
    endtask

    task automatic test_reset_midframe();
        out_t act, exp;
        bit found = 0;
        int first_nf = -1, wait_c;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (x_a == 11'd700 && pce_a === 1'b1) found = 1;
        end
        checks++;
        if (!found) $display("FAIL midframe_wait actual=timeout required=xpos 700");
        else passed++;
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        act = {pce_a, hs_a, vs_a, ve_a, nl_a, nf_a, x_a, y_a};
        checks++;
        if (act !== out_t'({6'b011000, 22'd0})) $display("FAIL midframe_reset_a actual=%h required=%h", act, out_t'({6'b011000, 22'd0}));
        else passed++;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            act = {pce_a, hs_a, vs_a, ve_a, nl_a, nf_a, x_a, y_a};
            exp = model(0, t_a);
            checks++;
            if (act !== exp) $display("FAIL midframe_a_cycle t=%0d actual=%h required=%h", t_a, act, exp);
            else passed++;
            if (nf_a === 1'b1 && first_nf < 0) first_nf = t_a;
        end
        checks++;
        if (first_nf != 4) $display("FAIL midframe_new_frame_delay actual=%0d required=4", first_nf);
        else passed++;
        $display("[tb] reset pulse at xpos=700 on default config");
        for (int k = 0; k < 2; k++) begin
            wait_c = int'($urandom_range(40, 590));
            repeat (wait_c) @(negedge clk);
            rst_c = 1'b1;
            @(negedge clk);
            rst_c = 1'b0;
            act = {pce_c, hs_c, vs_c, ve_c, nl_c, nf_c, x_c, y_c};
            checks++;
            if (act !== out_t'({6'b010000, 22'd0})) $display("FAIL random_reset_c actual=%h required=%h", act, out_t'({6'b010000, 22'd0}));
            else passed++;
            for (int i = 0; i < 650; i++) begin
                @(negedge clk);
                act = {pce_c, hs_c, vs_c, ve_c, nl_c, nf_c, x_c, y_c};
                exp = model(2, t_c);
                checks++;
                if (act !== exp) $display("FAIL random_reset_c_cycle t=%0d actual=%h required=%h", t_c, act, exp);
                else passed++;
            end
            $display("[tb] reset pulse on clkdiv=3 config after %0d clks", wait_c);
        end
    endtask

    task automatic test_wrap_corner();
        bit found = 0;
        for (int i = 0; i < 700 && !found; i++) begin
            @(negedge clk);
            if (x_c == 11'd19 && y_c == 11'd9 && pce_c === 1'b1) found = 1;
        end
        checks++;
        if (!found) $display("FAIL corner_wait actual=timeout required=xpos 19 ypos 9");
        else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if ({x_c, y_c, nl_c, nf_c} !== {11'd0, 11'd0, 1'b1, 1'b1})
            $display("FAIL corner_wrap actual x=%0d y=%0d nl=%b nf=%b required 0 0 1 1", x_c, y_c, nl_c, nf_c);
        else passed++;
        @(negedge clk);
        checks++;
        if ({nl_c, nf_c} !== 2'b00) $display("FAIL corner_strobes_clear actual nl=%b nf=%b required 0 0", nl_c, nf_c);
        else passed++;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (x_b == 11'd9 && y_b == 11'd5) found = 1;
        end
        @(negedge clk);
        checks++;
        if (!found || {x_b, y_b, nl_b, nf_b} !== {11'd0, 11'd0, 1'b1, 1'b1})
            $display("FAIL corner_wrap_b found=%0d x=%0d y=%0d nl=%b nf=%b required 0 0 1 1", found, x_b, y_b, nl_b, nf_b);
        else passed++;
        @(negedge clk);
        checks++;
        if ({x_b, nl_b, nf_b} !== {11'd1, 1'b0, 1'b0})
            $display("FAIL corner_after_b x=%0d nl=%b nf=%b required 1 0 0", x_b, nl_b, nf_b);
        else passed++;
        $display("[tb] frame wrap corners checked");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_default_lines();
        test_small_frame();
        test_scaled_frame();
        test_reset_midframe();
        test_wrap_corner();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
